// File: rtl/phase_to_amp.sv
// phase_to_amp: quarter-wave sine lookup with quadrant mirroring and sign,
// three register stages from phase word to DAC sample.
module phase_to_amp #(
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] phase,
    input  logic       phase_valid,
    output logic [7:0] amp,
    output logic       amp_valid
);

    typedef struct packed {
        logic       valid;
        logic       sign;
        logic [5:0] idx;
    } s1_t;

    typedef struct packed {
        logic       valid;
        logic       sign;
        logic [6:0] q;
    } s2_t;

    // Midscale for the DAC in offset-binary, zero in two's complement.
    localparam logic [7:0] AMP_RST = OFFSET_BIN ? 8'd128 : 8'd0;

    // round(127*sin(pi*(2i+1)/256)); half-LSB offset keeps it symmetric.
    function automatic logic [6:0] quarter_sine(input logic [5:0] i);
        logic [6:0] q;
        case (i)
            6'd0:    q = 7'd2;
            6'd1:    q = 7'd5;
            6'd2:    q = 7'd8;
            6'd3:    q = 7'd11;
            6'd4:    q = 7'd14;
            6'd5:    q = 7'd17;
            6'd6:    q = 7'd20;
            6'd7:    q = 7'd23;
            6'd8:    q = 7'd26;
            6'd9:    q = 7'd29;
            6'd10:   q = 7'd32;
            6'd11:   q = 7'd35;
            6'd12:   q = 7'd38;
            6'd13:   q = 7'd41;
            6'd14:   q = 7'd44;
            6'd15:   q = 7'd47;
            6'd16:   q = 7'd50;
            6'd17:   q = 7'd53;
            6'd18:   q = 7'd56;
            6'd19:   q = 7'd58;
            6'd20:   q = 7'd61;
            6'd21:   q = 7'd64;
            6'd22:   q = 7'd67;
            6'd23:   q = 7'd69;
            6'd24:   q = 7'd72;
            6'd25:   q = 7'd74;
            6'd26:   q = 7'd77;
            6'd27:   q = 7'd79;
            6'd28:   q = 7'd82;
            6'd29:   q = 7'd84;
            6'd30:   q = 7'd86;
            6'd31:   q = 7'd89;
            6'd32:   q = 7'd91;
            6'd33:   q = 7'd93;
            6'd34:   q = 7'd95;
            6'd35:   q = 7'd97;
            6'd36:   q = 7'd99;
            6'd37:   q = 7'd101;
            6'd38:   q = 7'd103;
            6'd39:   q = 7'd105;
            6'd40:   q = 7'd106;
            6'd41:   q = 7'd108;
            6'd42:   q = 7'd110;
            6'd43:   q = 7'd111;
            6'd44:   q = 7'd113;
            6'd45:   q = 7'd114;
            6'd46:   q = 7'd115;
            6'd47:   q = 7'd117;
            6'd48:   q = 7'd118;
            6'd49:   q = 7'd119;
            6'd50:   q = 7'd120;
            6'd51:   q = 7'd121;
            6'd52:   q = 7'd122;
            6'd53:   q = 7'd123;
            6'd54:   q = 7'd124;
            6'd55:   q = 7'd124;
            6'd56:   q = 7'd125;
            6'd57:   q = 7'd125;
            6'd58:   q = 7'd126;
            6'd59:   q = 7'd126;
            6'd60:   q = 7'd127;
            6'd61:   q = 7'd127;
            6'd62:   q = 7'd127;
            default: q = 7'd127;
        endcase
        return q;
    endfunction

    s1_t        s1_q;
    s2_t        s2_q;
    logic [5:0] idx_d;
    logic [7:0] s_d;
    logic [7:0] amp_d;

    always_comb begin
        idx_d = phase[6] ? ~phase[5:0] : phase[5:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
        end else begin
            s1_q.valid <= phase_valid;
            if (phase_valid) begin
                s1_q.sign <= phase[7];
                s1_q.idx  <= idx_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_q <= '0;
        end else begin
            s2_q.valid <= s1_q.valid;
            if (s1_q.valid) begin
                s2_q.sign <= s1_q.sign;
                s2_q.q    <= quarter_sine(s1_q.idx);
            end
        end
    end

    // Offset-binary is the signed sample with its MSB inverted.
    always_comb begin
        s_d   = s2_q.sign ? (8'd0 - {1'b0, s2_q.q}) : {1'b0, s2_q.q};
        amp_d = OFFSET_BIN ? {~s_d[7], s_d[6:0]} : s_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            amp       <= AMP_RST;
            amp_valid <= 1'b0;
        end else begin
            amp_valid <= s2_q.valid;
            if (s2_q.valid) begin
                amp <= amp_d;
            end
        end
    end

endmodule

// File: tb/tb_phase_to_amp.sv
// tb_phase_to_amp: directed checks of both output formats side by side,
// against hand values and an independent sine reference.
module tb_phase_to_amp;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] phase;
    logic       phase_valid;
    logic [7:0] amp_ob;
    logic [7:0] amp_tc;
    logic       valid_ob;
    logic       valid_tc;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    phase_to_amp #(.OFFSET_BIN(1'b1)) dut_ob (
        .clk(clk),
        .reset(reset),
        .phase(phase),
        .phase_valid(phase_valid),
        .amp(amp_ob),
        .amp_valid(valid_ob)
    );

    phase_to_amp #(.OFFSET_BIN(1'b0)) dut_tc (
        .clk(clk),
        .reset(reset),
        .phase(phase),
        .phase_valid(phase_valid),
        .amp(amp_tc),
        .amp_valid(valid_tc)
    );

    // Signed sample from the sine formula itself, not from a table.
    function automatic int ref_s(input logic [7:0] p);
        int  idx;
        int  q;
        real r;
        idx = p[6] ? (63 - int'(p[5:0])) : int'(p[5:0]);
        r   = 127.0 * $sin(3.14159265358979 * real'(2 * idx + 1) / 256.0);
        q   = $rtoi(r + 0.5);
        return p[7] ? -q : q;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        phase = 8'd0;
        phase_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (amp_ob !== 8'd128) begin
            fails++;
            $display("FAIL reset_amp_ob: got %0d want 128", amp_ob);
        end
        tests++;
        if (amp_tc !== 8'd0) begin
            fails++;
            $display("FAIL reset_amp_tc: got %0d want 0", amp_tc);
        end
        tests++;
        if (valid_ob !== 1'b0 || valid_tc !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b/%b want 0/0", valid_ob, valid_tc);
        end
        phase = 8'd64;
        phase_valid = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (valid_ob !== 1'b0 || amp_ob !== 8'd128) begin
            fails++;
            $display("FAIL reset_hold: got v=%b amp=%0d want v=0 amp=128",
                     valid_ob, amp_ob);
        end
        reset = 1'b0;
        phase_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (valid_ob !== 1'b0 || amp_ob !== 8'd128) begin
            fails++;
            $display("FAIL reset_idle: got v=%b amp=%0d want v=0 amp=128",
                     valid_ob, amp_ob);
        end
    endtask

    task automatic test_quadrants();
        logic [7:0] ph [4];
        logic [7:0] eo [4];
        logic [7:0] et [4];
        ph = '{8'd0, 8'd64, 8'd128, 8'd192};
        eo = '{8'd130, 8'd255, 8'd126, 8'd1};
        et = '{8'd2, 8'd127, 8'hFE, 8'h81};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++;
            if (i >= 3 && i < 7) begin
                if (valid_ob !== 1'b1 || amp_ob !== eo[i-3]
                    || valid_tc !== 1'b1 || amp_tc !== et[i-3]) begin
                    fails++;
                    $display("FAIL quad_%0d: got ob=%0d/%b tc=%0d/%b want ob=%0d tc=%0d",
                             i - 3, amp_ob, valid_ob, amp_tc, valid_tc,
                             eo[i-3], et[i-3]);
                end
            end else if (i < 3) begin
                if (valid_ob !== 1'b0) begin
                    fails++;
                    $display("FAIL quad_latency_%0d: got valid %b want 0", i, valid_ob);
                end
            end else begin
                if (valid_ob !== 1'b0 || amp_ob !== 8'd1) begin
                    fails++;
                    $display("FAIL quad_tail: got v=%b amp=%0d want v=0 amp=1",
                             valid_ob, amp_ob);
                end
            end
            if (i < 4) begin
                phase = ph[i];
                phase_valid = 1'b1;
            end else begin
                phase_valid = 1'b0;
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] got_ob [256];
        logic [7:0] got_tc [256];
        logic [7:0] want;
        for (int i = 0; i < 259; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                got_ob[i-3] = amp_ob;
                got_tc[i-3] = amp_tc;
                tests++;
                if (valid_ob !== 1'b1 || valid_tc !== 1'b1) begin
                    fails++;
                    $display("FAIL sweep_valid_%0d: got %b/%b want 1/1",
                             i - 3, valid_ob, valid_tc);
                end
                want = 8'(ref_s(8'(i - 3)) + 128);
                tests++;
                if (amp_ob !== want) begin
                    fails++;
                    $display("FAIL sweep_ob_%0d: got %0d want %0d", i - 3, amp_ob, want);
                end
                want = 8'(ref_s(8'(i - 3)));
                tests++;
                if (amp_tc !== want) begin
                    fails++;
                    $display("FAIL sweep_tc_%0d: got %0d want %0d", i - 3, amp_tc, want);
                end
            end
            if (i < 256) begin
                phase = 8'(i);
                phase_valid = 1'b1;
            end else begin
                phase_valid = 1'b0;
            end
        end
        for (int p = 0; p < 128; p++) begin
            tests++;
            if ((9'(got_ob[p]) + 9'(got_ob[p+128])) !== 9'd256) begin
                fails++;
                $display("FAIL sym_ob_%0d: got %0d+%0d want sum 256",
                         p, got_ob[p], got_ob[p+128]);
            end
            tests++;
            if (got_tc[p] !== 8'(8'd0 - got_tc[p+128])) begin
                fails++;
                $display("FAIL sym_tc_%0d: got %0d vs %0d want negated",
                         p, got_tc[p], got_tc[p+128]);
            end
        end
    endtask

    task automatic test_bubbles();
        logic [7:0] ph [4];
        logic       vl [4];
        logic [7:0] eo [4];
        logic [7:0] et [4];
        ph = '{8'd64, 8'd5, 8'd7, 8'd192};
        vl = '{1'b1, 1'b0, 1'b0, 1'b1};
        eo = '{8'd255, 8'd255, 8'd255, 8'd1};
        et = '{8'd127, 8'd127, 8'd127, 8'h81};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                tests++;
                if (valid_ob !== vl[i-3] || amp_ob !== eo[i-3]
                    || valid_tc !== vl[i-3] || amp_tc !== et[i-3]) begin
                    fails++;
                    $display("FAIL bubble_%0d: got ob=%0d/%b tc=%0d/%b want ob=%0d tc=%0d v=%b",
                             i - 3, amp_ob, valid_ob, amp_tc, valid_tc,
                             eo[i-3], et[i-3], vl[i-3]);
                end
            end
            if (i < 4) begin
                phase = ph[i];
                phase_valid = vl[i];
            end else begin
                phase_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            phase = 8'(i);
            phase_valid = 1'b1;
        end
        tests++;
        if (valid_ob !== 1'b1 || amp_ob !== 8'd136) begin
            fails++;
            $display("FAIL mid_stream: got v=%b amp=%0d want v=1 amp=136",
                     valid_ob, amp_ob);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if (amp_ob !== 8'd128 || amp_tc !== 8'd0
            || valid_ob !== 1'b0 || valid_tc !== 1'b0) begin
            fails++;
            $display("FAIL mid_async: got ob=%0d/%b tc=%0d/%b want 128/0 0/0",
                     amp_ob, valid_ob, amp_tc, valid_tc);
        end
        @(negedge clk);
        reset = 1'b0;
        phase = 8'd64;
        phase_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            tests++;
            if (k == 3) begin
                if (valid_ob !== 1'b1 || amp_ob !== 8'd255
                    || valid_tc !== 1'b1 || amp_tc !== 8'd127) begin
                    fails++;
                    $display("FAIL mid_first: got ob=%0d/%b tc=%0d/%b want 255/1 127/1",
                             amp_ob, valid_ob, amp_tc, valid_tc);
                end
            end else begin
                if (valid_ob !== 1'b0 || valid_tc !== 1'b0) begin
                    fails++;
                    $display("FAIL mid_stale_%0d: got valid %b/%b want 0/0",
                             k, valid_ob, valid_tc);
                end
            end
            phase = 8'(5 + k);
            phase_valid = 1'b0;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ph [4];
        logic [7:0] eo [4];
        logic [7:0] et [4];
        ph = '{8'd254, 8'd255, 8'd0, 8'd1};
        eo = '{8'd123, 8'd126, 8'd130, 8'd133};
        et = '{8'hFB, 8'hFE, 8'd2, 8'd5};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                tests++;
                if (valid_ob !== 1'b1 || amp_ob !== eo[i-3] || amp_tc !== et[i-3]) begin
                    fails++;
                    $display("FAIL wrap_%0d: got ob=%0d/%b tc=%0d want ob=%0d tc=%0d",
                             i - 3, amp_ob, valid_ob, amp_tc, eo[i-3], et[i-3]);
                end
            end
            if (i < 4) begin
                phase = ph[i];
                phase_valid = 1'b1;
            end else begin
                phase_valid = 1'b0;
            end
        end
    endtask

    task automatic test_peak();
        logic [7:0] ph [4];
        logic [7:0] got [4];
        logic [7:0] want;
        ph = '{8'd62, 8'd63, 8'd64, 8'd65};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                got[i-3] = amp_tc;
                want = 8'(ref_s(ph[i-3]));
                tests++;
                if (valid_tc !== 1'b1 || amp_tc !== want || amp_ob !== 8'd255) begin
                    fails++;
                    $display("FAIL peak_%0d: got tc=%0d ob=%0d v=%b want tc=%0d ob=255",
                             i - 3, amp_tc, amp_ob, valid_tc, want);
                end
            end
            if (i < 4) begin
                phase = ph[i];
                phase_valid = 1'b1;
            end else begin
                phase_valid = 1'b0;
            end
        end
        tests++;
        if (got[1] !== 8'd127 || got[2] !== 8'd127) begin
            fails++;
            $display("FAIL peak_hold: got %0d,%0d want 127,127", got[1], got[2]);
        end
        tests++;
        if (got[0] !== got[3]) begin
            fails++;
            $display("FAIL peak_sym: got %0d vs %0d want equal", got[0], got[3]);
        end
    endtask

    initial begin
        test_reset();
        test_quadrants();
        test_sweep();
        test_bubbles();
        test_reset_mid();
        test_wrap();
        test_peak();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/phase_to_amp.md
# phase_to_amp

Pipelined phase-to-amplitude converter for the DDS chain. It consumes the 8-bit phase word produced by the phase accumulator and returns one sine amplitude sample per phase sample. A 64-entry quarter-wave table plus quadrant mirroring and sign logic produce the result. The output feeds the DAC driver directly.

## Interface
- `OFFSET_BIN`, default 1: 1 = offset-binary output (DAC code 0..255); 0 = two's-complement output (-127..+127).
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all pipeline state immediately.
- `phase` input 8: phase word; 256 steps per cycle of the sine.
- `phase_valid` input 1: `phase` is a valid sample this cycle.
- `amp` output 8: amplitude sample, with the format set by `OFFSET_BIN`.
- `amp_valid` output 1: `amp` holds a valid sample this cycle.

## Operation
- Phase decode:
  - `phase[7]` is the sign: 0 gives a positive half-cycle, 1 gives a negative one.
  - `phase[6]` is the mirror bit: 1 gives index = ~`phase[5:0]`, 0 gives index = `phase[5:0]`.
- Quarter table: Q[i] = round(127·sin(π·(2i+1)/256)) for i = 0..63.
  - Q is 7-bit unsigned and monotonic non-decreasing.
  - Q[0] = 2, Q[63] = 127.
  - Half-LSB offset, so 0 and 127 are never both hit. Symmetry is exact and there is no ±128 case.
  - The table is a synthesizable constant (case ROM). Behaviour does not depend on RAM initialisation.
- Signed result S: +Q[index] if the sign bit is 0, −Q[index] if it is 1. S is 8-bit two's complement.
- Output mapping:
  - `OFFSET_BIN`=1: `amp` = S + 128, which equals the MSB-inverted form of S. Range 1..255.
  - `OFFSET_BIN`=0: `amp` = S.
- Pipeline, three register stages, advancing unconditionally every cycle (no stall, no backpressure):
  - S1: register `phase_valid`, the sign bit and the mirrored 6-bit index.
  - S2: register Q[index], sign and valid.
  - S3: register the final `amp` and `amp_valid`.
- Valid handling:
  - A valid bit travels with each sample.
  - Bubbles (`phase_valid`=0) propagate as `amp_valid`=0.
  - While `amp_valid`=0, `amp` holds its last valid value and does not toggle. Data registers load only when their stage valid is set.
- Reset:
  - Asserting `reset` clears all stage valids and data registers asynchronously.
  - Reset value of `amp`: 8'd128 when `OFFSET_BIN`=1 (DAC midscale), 8'd0 when `OFFSET_BIN`=0.
  - Reset value of `amp_valid`: 0.
- Reset mid-operation: all in-flight samples are discarded. The first post-reset output is the sample presented on the first rising edge after `reset` deasserts.

## Timing
- Latency: the sample accepted on rising edge N appears on `amp`, with `amp_valid`=1, after edge N+2. It is visible for the cycle following edge N+2, i.e. 3 register stages.
- Throughput: 1 sample per clock, sustained indefinitely.
- Wrap-around: phase 255 followed by phase 0 needs no special handling. Output goes −2 → +2 (offset-binary 126 → 130).
- Quadrant boundaries:
  - phase 63 → 64 gives Q[63], Q[63] (127, 127): the peak is held for two samples by design.
  - phase 127 → 128 gives +2 → −2.
- Reset deassertion: the first valid output is 3 cycles after the first accepted `phase_valid`. `amp_valid` stays 0 until then.
- Asynchronous assertion of `reset` forces `amp` and `amp_valid` to their reset values within the same cycle, without waiting for a clock edge.

## Test plan
- Quadrant points, `OFFSET_BIN`=1: phase 0, 64, 128, 192 with `phase_valid`=1 on consecutive cycles → `amp` = 130, 255, 126, 1 on cycles 3..6, with `amp_valid`=1 throughout.
- Full sweep, both `OFFSET_BIN` settings: phase 0..255 back-to-back → each output equals the reference model. Check symmetry: `amp`(p) + `amp`(p+128) = 256 in offset-binary; S(p) = −S(p+128) in two's complement.
- Bubbles: valid pattern 1,0,0,1 with phases 64, x, x, 192 → `amp_valid` pattern 1,0,0,1 delayed by 3. During the gaps, `amp` holds 255.
- Reset mid-stream:
  - Stream phases 0..10.
  - Assert `reset` between edges at cycle 5 → `amp`=128 and `amp_valid`=0 immediately, with no stale samples after release.
  - Next phase 64 → 255 exactly 3 cycles later.
- Wrap-around: phases 254, 255, 0, 1 → two's complement −4?/−2/+2/+4 per table (Q[1]=round(127·sin(3π/256))=5, so −5, −2, 2, 5). Output must be exactly these values in order, with no glitch at the wrap.
- Peak hold: phases 62, 63, 64, 65 → Q = 127?; check against the model that outputs 63/64 are both Q[63]=127 and that 62/65 are equal.
